// File: rtl/leaf_inject_ctrl_if.sv
// ---------------------------------------------------------------------------
// leaf_inject_ctrl_if
// Purpose : groups the BFT-side packet path, the stream path, the instruction
//           handshake and the command request/status signals of
//           leaf_inject_ctrl into one bundle.
// Modports:
//   master - request side (stream source, instruction source, host control)
//            drives resend, stream_in, cmd_leaf, instr_data, instr_valid,
//            start_req, clear_req; observes dout, resend_out, instr_ready,
//            busy, pkt_count.
//   slave  - the leaf_inject_ctrl block itself (directions reversed).
// ---------------------------------------------------------------------------
interface leaf_inject_ctrl_if #(
  parameter int PACKET_BITS   = 97,
  parameter int NUM_LEAF_BITS = 6
);
  logic [PACKET_BITS-1:0]   dout_leaf_interface2bft;
  logic                     resend;
  logic [PACKET_BITS-1:0]   stream_in;
  logic                     resend_out;
  logic [NUM_LEAF_BITS-1:0] cmd_leaf;
  logic [31:0]              instr_data;
  logic                     instr_valid;
  logic                     instr_ready;
  logic                     start_req;
  logic                     clear_req;
  logic                     busy;
  logic [15:0]              pkt_count;

  modport master (
    output resend, stream_in, cmd_leaf, instr_data, instr_valid,
           start_req, clear_req,
    input  dout_leaf_interface2bft, resend_out, instr_ready, busy, pkt_count
  );

  modport slave (
    input  resend, stream_in, cmd_leaf, instr_data, instr_valid,
           start_req, clear_req,
    output dout_leaf_interface2bft, resend_out, instr_ready, busy, pkt_count
  );
endinterface

// File: rtl/leaf_inject_ctrl.sv
// ---------------------------------------------------------------------------
// leaf_inject_ctrl
// Purpose : injects packets into a BFT leaf. Each edge the registered output
//           carries one of: a replay of the last packet (on resend), a
//           forwarded stream packet, or a locally generated command packet
//           (CLEAR_START, SET_START, or an instruction from a small FIFO).
// Ports   :
//   clk    - single clock, all logic on posedge
//   reset  - synchronous active-high reset
//   bus    - leaf_inject_ctrl_if.slave: dout_leaf_interface2bft (registered
//            packet), resend/resend_out, stream_in, cmd_leaf, instr_data/
//            instr_valid/instr_ready, start_req, clear_req, busy, pkt_count
// Config  : define LEAF_INJECT_PKT_COUNT_EN to count generated command
//           packets on pkt_count; otherwise pkt_count is tied to zero.
// ---------------------------------------------------------------------------
module leaf_inject_ctrl #(
  parameter int PACKET_BITS      = 97,
  parameter int PAYLOAD_BITS     = 64,
  parameter int NUM_LEAF_BITS    = 6,
  parameter int NUM_PORT_BITS    = 4,
  parameter int INSTR_FIFO_DEPTH = 4
) (
  input logic             clk,
  input logic             reset,
  leaf_inject_ctrl_if.slave bus
);

  localparam int ADDR_BITS = $clog2(INSTR_FIFO_DEPTH);
  localparam int CNT_BITS  = ADDR_BITS + 1;

  localparam logic [1:0] TYPE_INSTR = 2'd1;
  localparam logic [1:0] TYPE_START = 2'd2;
  localparam logic [1:0] TYPE_CLEAR = 2'd3;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } state_t;

  typedef enum logic [2:0] {
    SEL_ZERO   = 3'd0,
    SEL_REPLAY = 3'd1,
    SEL_STREAM = 3'd2,
    SEL_CLEAR  = 3'd3,
    SEL_START  = 3'd4,
    SEL_INSTR  = 3'd5
  } sel_t;

  // Builds a generated command packet; all unlisted fields are zero.
  function automatic logic [PACKET_BITS-1:0] make_pkt(
    input logic [1:0]               type_code,
    input logic [31:0]              word,
    input logic [NUM_LEAF_BITS-1:0] leaf
  );
    logic [PACKET_BITS-1:0] pkt;
    pkt = '0;
    pkt[PACKET_BITS-1] = 1'b1;
    pkt[PACKET_BITS-2 -: NUM_LEAF_BITS] = leaf;
    pkt[PACKET_BITS-2-NUM_LEAF_BITS -: NUM_PORT_BITS] = '0;
    pkt[PAYLOAD_BITS+1:PAYLOAD_BITS] = type_code;
    pkt[31:0] = word;
    return pkt;
  endfunction

  logic [31:0]            fifo_mem_r [INSTR_FIFO_DEPTH];
  logic [ADDR_BITS-1:0]   wr_ptr_r;
  logic [ADDR_BITS-1:0]   rd_ptr_r;
  logic [CNT_BITS-1:0]    count_r;
  logic                   fifo_empty_s;
  logic                   fifo_full_s;
  logic                   push_s;
  logic                   pop_s;

  logic                   start_pend_r;
  logic                   clear_pend_r;
  state_t                 state_r;
  state_t                 state_next_s;
  sel_t                   cmd_sel_s;
  sel_t                   sel_s;
  logic                   work_s;
  logic                   gen_s;

  logic [PACKET_BITS-1:0] dout_r;
  logic [PACKET_BITS-1:0] last_sent_r;
  logic [PACKET_BITS-1:0] next_dout_s;

  assign fifo_empty_s = (count_r == {CNT_BITS{1'b0}});
  assign fifo_full_s  = (count_r == CNT_BITS'(INSTR_FIFO_DEPTH));
  assign push_s       = bus.instr_valid && !fifo_full_s;
  assign pop_s        = (sel_s == SEL_INSTR);
  assign work_s       = !fifo_empty_s || start_pend_r || clear_pend_r;
  assign gen_s        = (sel_s == SEL_CLEAR) || (sel_s == SEL_START) ||
                        (sel_s == SEL_INSTR);

  // Which command packet would go out if the slot were free. SET_START waits
  // for an empty FIFO so every earlier instruction leaves first.
  always_comb begin
    cmd_sel_s = SEL_ZERO;
    if (clear_pend_r) begin
      cmd_sel_s = SEL_CLEAR;
    end else if (start_pend_r && fifo_empty_s) begin
      cmd_sel_s = SEL_START;
    end else if (!fifo_empty_s) begin
      cmd_sel_s = SEL_INSTR;
    end else begin
      cmd_sel_s = SEL_ZERO;
    end
  end

  // Command FSM next state and output-slot selection; replay and stream
  // traffic pre-empt command generation without changing pendings.
  always_comb begin
    state_next_s = state_r;
    sel_s        = SEL_ZERO;
    case (state_r)
      ST_IDLE: begin
        if (bus.resend) begin
          sel_s = SEL_REPLAY;
        end else if (bus.stream_in[PACKET_BITS-1]) begin
          sel_s = SEL_STREAM;
        end else if (work_s) begin
          sel_s        = cmd_sel_s;
          state_next_s = ST_EMIT;
        end else begin
          sel_s = SEL_ZERO;
        end
      end
      ST_EMIT: begin
        if (bus.resend) begin
          sel_s = SEL_REPLAY;
        end else if (bus.stream_in[PACKET_BITS-1]) begin
          sel_s = SEL_STREAM;
        end else begin
          sel_s = cmd_sel_s;
        end
        if (!work_s) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_EMIT;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
        sel_s        = SEL_ZERO;
      end
    endcase
  end

  // Output packet mux.
  always_comb begin
    next_dout_s = '0;
    case (sel_s)
      SEL_REPLAY: next_dout_s = last_sent_r;
      SEL_STREAM: next_dout_s = bus.stream_in;
      SEL_CLEAR:  next_dout_s = make_pkt(TYPE_CLEAR, 32'd0, bus.cmd_leaf);
      SEL_START:  next_dout_s = make_pkt(TYPE_START, 32'd0, bus.cmd_leaf);
      SEL_INSTR:  next_dout_s = make_pkt(TYPE_INSTR, fifo_mem_r[rd_ptr_r],
                                         bus.cmd_leaf);
      default:    next_dout_s = '0;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Output register and replay copy; a replay never refreshes the copy.
  always_ff @(posedge clk) begin
    if (reset) begin
      dout_r      <= '0;
      last_sent_r <= '0;
    end else begin
      dout_r <= next_dout_s;
      if ((sel_s != SEL_REPLAY) && (next_dout_s != '0)) begin
        last_sent_r <= next_dout_s;
      end
    end
  end

  // Sticky request flags; a request arriving while pending merges into it.
  always_ff @(posedge clk) begin
    if (reset) begin
      start_pend_r <= 1'b0;
      clear_pend_r <= 1'b0;
    end else begin
      start_pend_r <= bus.start_req || (start_pend_r && (sel_s != SEL_START));
      clear_pend_r <= bus.clear_req || (clear_pend_r && (sel_s != SEL_CLEAR));
    end
  end

  // Instruction FIFO storage and pointers; pointers wrap at the depth.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      for (int i = 0; i < INSTR_FIFO_DEPTH; i++) begin
        fifo_mem_r[i] <= 32'd0;
      end
    end else begin
      if (push_s) begin
        fifo_mem_r[wr_ptr_r] <= bus.instr_data;
        wr_ptr_r             <= wr_ptr_r + ADDR_BITS'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + ADDR_BITS'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_BITS'(1);
        2'b01:   count_r <= count_r - CNT_BITS'(1);
        default: count_r <= count_r;
      endcase
    end
  end

`ifdef LEAF_INJECT_PKT_COUNT_EN
  logic [15:0] pkt_cnt_r;

  // Counts generated command packets only.
  always_ff @(posedge clk) begin
    if (reset) begin
      pkt_cnt_r <= 16'd0;
    end else if (gen_s) begin
      pkt_cnt_r <= pkt_cnt_r + 16'd1;
    end else begin
      pkt_cnt_r <= pkt_cnt_r;
    end
  end

  assign bus.pkt_count = pkt_cnt_r;
`else
  logic unused_gen_s;
  assign unused_gen_s  = gen_s;
  assign bus.pkt_count = 16'd0;
`endif

  assign bus.dout_leaf_interface2bft = dout_r;
  assign bus.resend_out              = bus.resend;
  assign bus.instr_ready             = !fifo_full_s;
  assign bus.busy                    = work_s;

endmodule

// File: tb/tb_leaf_inject_ctrl.sv
// ---------------------------------------------------------------------------
// tb_leaf_inject_ctrl
// Purpose : directed self-checking bench for leaf_inject_ctrl. Inputs change
//           1 time unit after each rising edge; outputs are checked there.
// ---------------------------------------------------------------------------
module tb_leaf_inject_ctrl;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  leaf_inject_ctrl_if #(.PACKET_BITS(97), .NUM_LEAF_BITS(6)) bus ();

  leaf_inject_ctrl #(
    .PACKET_BITS     (97),
    .PAYLOAD_BITS    (64),
    .NUM_LEAF_BITS   (6),
    .NUM_PORT_BITS   (4),
    .INSTR_FIFO_DEPTH(4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [96:0] cmd_pkt(input logic [5:0] leaf,
                                          input logic [1:0] t,
                                          input logic [31:0] w);
    logic [96:0] p;
    p = '0;
    p[96] = 1'b1;
    p[95:90] = leaf;
    p[65:64] = t;
    p[31:0] = w;
    return p;
  endfunction

  function automatic logic [96:0] stream_pkt(input int i);
    logic [96:0] p;
    p = '0;
    p[96] = 1'b1;
    p[95:90] = 6'h2A;
    p[89:86] = 4'h7;
    p[63:0] = 64'h0123_4567_89AB_CDE0 + 64'(i);
    return p;
  endfunction

  function automatic logic [15:0] exp_cnt(input int n);
`ifdef LEAF_INJECT_PKT_COUNT_EN
    return 16'(n);
`else
    return 16'(0 * n);
`endif
  endfunction

  task automatic check(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset = 1'b1;
    bus.resend = 1'b0;
    bus.stream_in = '0;
    bus.cmd_leaf = 6'd5;
    bus.instr_data = 32'd0;
    bus.instr_valid = 1'b0;
    bus.start_req = 1'b0;
    bus.clear_req = 1'b0;

    // Reset state
    tick();
    tick();
    check("rst_dout", bus.dout_leaf_interface2bft, 97'd0);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_ready", bus.instr_ready, 1'b1);
    check("rst_cnt", bus.pkt_count, 16'd0);
    reset = 1'b0;

    // Resend before anything sent replays zero
    bus.resend = 1'b1;
    #1;
    check("resend_out_hi", bus.resend_out, 1'b1);
    tick();
    check("replay_empty", bus.dout_leaf_interface2bft, 97'd0);
    bus.resend = 1'b0;
    #1;
    check("resend_out_lo", bus.resend_out, 1'b0);

    // Two instructions to leaf 5
    bus.instr_valid = 1'b1;
    bus.instr_data = 32'h0000_0013;
    tick();
    bus.instr_data = 32'h00A0_0093;
    tick();
    check("i1_pkt", bus.dout_leaf_interface2bft, cmd_pkt(6'd5, 2'd1, 32'h0000_0013));
    check("i1_busy", bus.busy, 1'b1);
    bus.instr_valid = 1'b0;
    tick();
    check("i2_pkt", bus.dout_leaf_interface2bft, cmd_pkt(6'd5, 2'd1, 32'h00A0_0093));
    check("i2_busy", bus.busy, 1'b0);
    tick();
    check("i_idle", bus.dout_leaf_interface2bft, 97'd0);
    check("i_cnt", bus.pkt_count, exp_cnt(2));

    // Replay of 0xDEADBEEF, FIFO head kept
    bus.instr_valid = 1'b1;
    bus.instr_data = 32'hDEAD_BEEF;
    tick();
    bus.instr_data = 32'h1111_1111;
    tick();
    check("db_pkt", bus.dout_leaf_interface2bft, cmd_pkt(6'd5, 2'd1, 32'hDEAD_BEEF));
    bus.instr_valid = 1'b0;
    bus.resend = 1'b1;
    #1;
    check("db_resend_out", bus.resend_out, 1'b1);
    tick();
    check("db_replay", bus.dout_leaf_interface2bft, cmd_pkt(6'd5, 2'd1, 32'hDEAD_BEEF));
    bus.resend = 1'b0;
    tick();
    check("db_head", bus.dout_leaf_interface2bft, cmd_pkt(6'd5, 2'd1, 32'h1111_1111));
    tick();
    check("db_idle", bus.dout_leaf_interface2bft, 97'd0);
    check("db_cnt", bus.pkt_count, exp_cnt(4));

    // SET_START after both instructions
    bus.cmd_leaf = 6'd9;
    bus.instr_valid = 1'b1;
    bus.instr_data = 32'h0010_0113;
    tick();
    bus.instr_data = 32'h0020_0193;
    bus.start_req = 1'b1;
    tick();
    check("s_i1", bus.dout_leaf_interface2bft, cmd_pkt(6'd9, 2'd1, 32'h0010_0113));
    bus.instr_valid = 1'b0;
    bus.start_req = 1'b0;
    tick();
    check("s_i2", bus.dout_leaf_interface2bft, cmd_pkt(6'd9, 2'd1, 32'h0020_0193));
    check("s_busy", bus.busy, 1'b1);
    tick();
    check("s_start", bus.dout_leaf_interface2bft, cmd_pkt(6'd9, 2'd2, 32'd0));
    tick();
    check("s_idle", bus.dout_leaf_interface2bft, 97'd0);
    check("s_busy_lo", bus.busy, 1'b0);
    check("s_cnt", bus.pkt_count, exp_cnt(7));

    // Reset mid-operation discards queued work
    bus.instr_valid = 1'b1;
    bus.instr_data = 32'h5555_5555;
    bus.start_req = 1'b1;
    tick();
    bus.instr_valid = 1'b0;
    bus.start_req = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mr_dout", bus.dout_leaf_interface2bft, 97'd0);
    check("mr_busy", bus.busy, 1'b0);
    check("mr_cnt", bus.pkt_count, 16'd0);
    tick();
    check("mr_nothing", bus.dout_leaf_interface2bft, 97'd0);
    bus.resend = 1'b1;
    tick();
    check("mr_replay", bus.dout_leaf_interface2bft, 97'd0);
    bus.resend = 1'b0;

    // Simultaneous clear and start requests
    bus.cmd_leaf = 6'd5;
    bus.start_req = 1'b1;
    bus.clear_req = 1'b1;
    tick();
    bus.start_req = 1'b0;
    bus.clear_req = 1'b0;
    check("cs_busy", bus.busy, 1'b1);
    tick();
    check("cs_clear", bus.dout_leaf_interface2bft, cmd_pkt(6'd5, 2'd3, 32'd0));
    tick();
    check("cs_start", bus.dout_leaf_interface2bft, cmd_pkt(6'd5, 2'd2, 32'd0));
    tick();
    check("cs_idle", bus.dout_leaf_interface2bft, 97'd0);
    check("cs_cnt", bus.pkt_count, exp_cnt(2));

    // Fill FIFO while stream_in owns every slot
    bus.instr_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.instr_data = 32'hA000_0000 + 32'(i);
      bus.stream_in = stream_pkt(i);
      tick();
      check("st_fwd", bus.dout_leaf_interface2bft, stream_pkt(i));
    end
    check("st_full", bus.instr_ready, 1'b0);
    bus.instr_valid = 1'b0;
    bus.stream_in = stream_pkt(4);
    tick();
    check("st_fwd4", bus.dout_leaf_interface2bft, stream_pkt(4));
    check("st_full2", bus.instr_ready, 1'b0);
    bus.stream_in = '0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("st_drain", bus.dout_leaf_interface2bft,
            cmd_pkt(6'd5, 2'd1, 32'hA000_0000 + 32'(i)));
      check("st_ready", bus.instr_ready, 1'b1);
    end
    tick();
    check("st_idle", bus.dout_leaf_interface2bft, 97'd0);
    check("st_busy", bus.busy, 1'b0);
    check("st_cnt", bus.pkt_count, exp_cnt(6));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/leaf_inject_ctrl.md
LEAF_INJECT_CTRL -- requirements
Module: leaf_inject_ctrl

Interface
REQ-001 Parameter PACKET_BITS, 97, packet width: [96] valid, [95:90] leaf, [89:86] port, [65:64] type code, [63:0] payload.
REQ-002 Parameter PAYLOAD_BITS, 64, type code sits at [PAYLOAD_BITS+1:PAYLOAD_BITS].
REQ-003 Parameter NUM_LEAF_BITS, 6, destination leaf field width.
REQ-004 Parameter NUM_PORT_BITS, 4, destination port field width.
REQ-005 Parameter INSTR_FIFO_DEPTH, 4, instruction FIFO entries (power of two, >=2).
REQ-006 clk  in  1  single clock; all logic on posedge.
REQ-007 reset  in  1  synchronous, active-high reset.
REQ-008 dout_leaf_interface2bft  out  PACKET_BITS  registered packet toward BFT leaf.
REQ-009 resend  in  1  BFT rejected previous packet; replay required.
REQ-010 stream_in  in  PACKET_BITS  preformatted packet from stream flow control; valid when MSB=1.
REQ-011 resend_out  out  1  resend request to stream source.
REQ-012 cmd_leaf  in  NUM_LEAF_BITS  destination leaf for generated command packets.
REQ-013 instr_data  in  32  RISC-V instruction word.
REQ-014 instr_valid  in  1  instr_data valid.
REQ-015 instr_ready  out  1  FIFO can accept; transfer when valid&&ready.
REQ-016 start_req  in  1  one-cycle request to send SET_START packet.
REQ-017 clear_req  in  1  one-cycle request to send CLEAR_START packet.
REQ-018 busy  out  1  FIFO non-empty or any request pending.
REQ-019 pkt_count  out  16  generated-packet counter (see Configuration).

Function
REQ-020 Generated packets SHALL be: valid=1, leaf=cmd_leaf sampled at generation edge, port=0, bits [85:66]=0, type code 1 (instr, payload[31:0]=FIFO head, payload[63:32]=0), 2 (SET_START, payload 0), 3 (CLEAR_START, payload 0).
REQ-021 Per-edge priority SHALL be: resend replay > valid stream_in > CLEAR_START pending > SET_START pending (only when FIFO empty) > FIFO head > dout<=0.
REQ-022 resend=1: dout SHALL load last_sent (0 if nothing sent since reset); FIFO not popped, pendings unchanged, stream_in not forwarded.
REQ-023 resend_out SHALL equal resend combinationally; stream_in is never dropped otherwise.
REQ-024 Valid stream_in SHALL appear unmodified on dout after exactly one edge.
REQ-025 last_sent SHALL update to each new nonzero packet driven (not on replay).
REQ-026 start_req/clear_req SHALL set sticky pending flags, cleared when that packet is emitted; repeat request while pending is merged; simultaneous start_req and clear_req: CLEAR_START emitted first, then SET_START.
REQ-027 SET_START SHALL not be emitted until every instruction accepted before start_req was emitted.
REQ-028 FIFO: instr_ready = !full; simultaneous push and pop when full not allowed (ready low); push and pop same edge when non-empty SHALL keep count; pointers wrap modulo INSTR_FIFO_DEPTH.
REQ-029 Command FSM states IDLE, EMIT; IDLE->EMIT when any request/FIFO work exists and slot free; EMIT->IDLE when FIFO empty and no pending flags.

Reset
REQ-030 On reset: dout=0, last_sent=0, FIFO empty, pendings=0, FSM=IDLE, pkt_count=0, instr_ready=1 next cycle, busy=0.
REQ-031 Reset mid-operation SHALL discard queued instructions and pendings without emitting them.

Configuration
REQ-032 Macro LEAF_INJECT_PKT_COUNT_EN defined: pkt_count SHALL increment (wrapping at 16 bits) per generated command packet emitted, excluding replays and forwarded stream packets.
REQ-033 Macro undefined: pkt_count SHALL be constant 0 and no counter logic instantiated.

Verification
REQ-034 Push 0x00000013, 0x00A00093, cmd_leaf=5 -> two packets leaf=5, port=0, type=1, payloads in order; busy falls after second.
REQ-035 Push 4 words without pops while stream_in valid continuously -> instr_ready=0 after 4th; stream packets forwarded each cycle; instructions drain afterwards.
REQ-036 Push 2 words then start_req same cycle as 2nd push -> SET_START (type 2) emitted after both instructions.
REQ-037 Emit instruction 0xDEADBEEF, assert resend next cycle -> same packet replayed, resend_out=1, FIFO head unchanged.
REQ-038 start_req and clear_req same cycle -> type 3 then type 2 packets; with macro, pkt_count=2; without, 0.
